// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared definitions for the debug-packet UART framer.
//   - tx_state_e : serializer FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   - FRAME_BYTES: bytes per frame (sync, header, 4 data, checksum)
//   - SYNC_BYTE_DEFAULT: default first byte of every frame
//   - KIND_* : packet class codes, shared with the upstream sequencer
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int         FRAME_BYTES       = 7;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [1:0] KIND_REG   = 2'b00;
    localparam logic [1:0] KIND_ALU   = 2'b01;
    localparam logic [1:0] KIND_INST  = 2'b10;
    localparam logic [1:0] KIND_OTHER = 2'b11;

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: bit timer plus single-byte UART serializer (8N1, or 8E1 when
// UART_FRAME_PARITY_EN is defined).
// Ports:
//   clk, resetn   : clock, synchronous active-low reset
//   byte_in_i     : byte to send, sampled on the byte_valid_i && byte_ready_o edge
//   byte_valid_i  : a byte is offered
//   byte_ready_o  : serializer can take a byte this cycle
//   tx_o          : registered UART line, idle high
//   state_o       : current FSM state (debug)
// Handshake: a byte transfers on a rising clk where byte_valid_i and
// byte_ready_o are both 1. byte_ready_o is high in IDLE and also on the last
// cycle of the stop bit, so a byte offered then starts its start bit with no
// idle gap after the previous stop bit.
module uart_byte_tx
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] byte_in_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_o,
    output logic       tx_o,
    output tx_state_e  state_o
);

    localparam int             TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
`ifdef UART_FRAME_PARITY_EN
    logic          parity_q;
`endif

    logic last_tick;
    logic load;

    assign last_tick    = (timer_q == LAST);
    assign byte_ready_o = (state_q == ST_IDLE) || ((state_q == ST_STOP) && last_tick);
    assign load         = byte_valid_i && byte_ready_o;
    assign tx_o         = tx_q;
    assign state_o      = state_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_FRAME_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (load) begin
            state_q   <= ST_START;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= byte_in_i;
            tx_q      <= 1'b0;
`ifdef UART_FRAME_PARITY_EN
            parity_q  <= ^byte_in_i;
`endif
        end else if (state_q != ST_IDLE) begin
            if (!last_tick) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
                case (state_q)
                    ST_START: begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                    ST_DATA: begin
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_FRAME_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            // LSB first: the next bit is always bit 1 of the
                            // not-yet-shifted register.
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end
`ifdef UART_FRAME_PARITY_EN
                    ST_PARITY: begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
`endif
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: frames one debug packet (kind, addr, 32-bit data) as
// 7 bytes -- SYNC, {kind,addr,0}, data[31:24..7:0], XOR checksum -- and sends
// them back-to-back as UART 8N1 on tx. Define UART_FRAME_PARITY_EN to add an
// even-parity bit to every byte (8E1).
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   uart_send_en : one-cycle request; data/addr/kind valid in the same cycle
//   data, addr, kind : packet fields
//   tx           : UART line, idle high, registered
//   busy         : frame in progress (requests are dropped while high)
//   done         : one-cycle pulse on the edge that ends the frame
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_send_en,
    input  logic [31:0] data,
    input  logic [4:0]  addr,
    input  logic [1:0]  kind,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES);

    logic        busy_q;
    logic        done_q;
    logic [2:0]  byte_idx_q;   // index of the next byte to hand to the serializer
    logic [31:0] data_q;
    logic [4:0]  addr_q;
    logic [1:0]  kind_q;

    logic        accept;
    logic [7:0]  header;
    logic [7:0]  checksum;
    logic [7:0]  byte_mux;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    tx_state_e   ser_state;

    assign accept   = uart_send_en && !busy_q;
    assign header   = {kind_q, addr_q, 1'b0};
    assign checksum = header ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];

    always_comb begin
        byte_mux = SYNC_BYTE;
        case (byte_idx_q)
            3'd1:    byte_mux = header;
            3'd2:    byte_mux = data_q[31:24];
            3'd3:    byte_mux = data_q[23:16];
            3'd4:    byte_mux = data_q[15:8];
            3'd5:    byte_mux = data_q[7:0];
            3'd6:    byte_mux = checksum;
            default: byte_mux = SYNC_BYTE;
        endcase
    end

    // The sync byte is offered straight from the request so its start bit is
    // on the line in the cycle right after the accept edge.
    assign byte_in    = accept ? SYNC_BYTE : byte_mux;
    assign byte_valid = accept || (busy_q && (byte_idx_q != LAST_IDX));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_idx_q <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            kind_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q     <= 1'b1;
                byte_idx_q <= 3'd1;
                data_q     <= data;
                addr_q     <= addr;
                kind_q     <= kind;
            end else if (busy_q && byte_ready) begin
                // With every byte handed over, the serializer becoming ready
                // again marks the end of the final stop bit.
                if (byte_idx_q == LAST_IDX) begin
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    byte_idx_q <= '0;
                end else begin
                    byte_idx_q <= byte_idx_q + 3'd1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk          (clk),
        .resetn       (resetn),
        .byte_in_i    (byte_in),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .tx_o         (tx),
        .state_o      (ser_state)
    );

    // Serializer state is kept visible here for probing; the frame logic
    // itself needs only the ready handshake.
    tx_state_e dbg_ser_state;
    assign dbg_ser_state = ser_state;

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: directed bench for uart_frame_tx with CLKS_PER_BIT=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Sample index 0 is the cycle right after the accept edge.
module tb_uart_frame_tx;
    import uart_frame_pkg::*;

    localparam int CPB = 4;
`ifdef UART_FRAME_PARITY_EN
    localparam int BPF = 11;
`else
    localparam int BPF = 10;
`endif
    localparam int FRAME_LEN = 7 * BPF * CPB;
    localparam int CAP_MAX   = 700;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        uart_send_en = 1'b0;
    logic [31:0] data = '0;
    logic [4:0]  addr = '0;
    logic [1:0]  kind = '0;
    logic        tx;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    logic       cap_tx   [CAP_MAX];
    logic       cap_busy [CAP_MAX];
    logic       cap_done [CAP_MAX];
    logic [7:0] exp_b    [7];

    uart_frame_tx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_send_en (uart_send_en),
        .data         (data),
        .addr         (addr),
        .kind         (kind),
        .tx           (tx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Expected frame bytes B0..B6 packed as {B0,B1,...,B6}.
    task automatic load_exp(input logic [55:0] v);
        for (int k = 0; k < 7; k++) exp_b[k] = v[55 - 8*k -: 8];
    endtask

    task automatic send(input logic [1:0] k, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        kind = k; addr = a; data = d; uart_send_en = 1'b1;
        @(negedge clk);
        uart_send_en = 1'b0;
    endtask

    // Records n samples; at sample drop_at a zero-data request is strobed.
    task automatic capture(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            cap_tx[i] = tx; cap_busy[i] = busy; cap_done[i] = done;
            if (i == drop_at) begin
                data = 32'h0; kind = 2'b00; addr = 5'd0; uart_send_en = 1'b1;
            end else begin
                uart_send_en = 1'b0;
            end
            @(negedge clk);
        end
        uart_send_en = 1'b0;
    endtask

    // Reference line level for sample i of a frame carrying exp_b.
    function automatic logic exp_tx(input int i);
        int b; int k; int p;
        b = i / CPB; k = b / BPF; p = b % BPF;
        if (b >= 7 * BPF) return 1'b1;
        if (p == 0) return 1'b0;
        if (p <= 8) return exp_b[k][p-1];
        if (BPF == 11 && p == 9) return ^exp_b[k];
        return 1'b1;
    endfunction

    // Reads byte k from the captured line at mid-bit.
    function automatic logic [7:0] decode(input int k);
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = cap_tx[(k*BPF + 1 + j)*CPB + CPB/2];
        return v;
    endfunction

    function automatic int first_tx_err(input int n);
        for (int i = 0; i < n; i++) if (cap_tx[i] !== exp_tx(i)) return i;
        return -1;
    endfunction

    function automatic int first_busy_err(input int n);
        for (int i = 0; i < n; i++) if (cap_busy[i] !== (i < FRAME_LEN)) return i;
        return -1;
    endfunction

    function automatic int done_count(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (cap_done[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        resetn = 1'b1;
        begin
            int bad_tx = 0, bad_busy = 0, bad_done = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (tx !== 1'b1) bad_tx++;
                if (busy !== 1'b0) bad_busy++;
                if (done !== 1'b0) bad_done++;
            end
            checks++; if (bad_tx != 0)   begin failures++; $display("FAIL idle_tx low_cycles=%0d exp=0", bad_tx); end
            checks++; if (bad_busy != 0) begin failures++; $display("FAIL idle_busy high_cycles=%0d exp=0", bad_busy); end
            checks++; if (bad_done != 0) begin failures++; $display("FAIL idle_done high_cycles=%0d exp=0", bad_done); end
        end
    endtask

    task automatic test_nominal();
        int e;
        load_exp(56'hA5_C2_12_34_56_78_CA);
        send(KIND_OTHER, 5'd1, 32'h12345678);
        capture(FRAME_LEN + 20, -1);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (decode(k) !== exp_b[k]) begin failures++; $display("FAIL nominal_byte%0d got=%h exp=%h", k, decode(k), exp_b[k]); end
        end
        e = first_tx_err(FRAME_LEN + 20);
        checks++; if (e >= 0) begin failures++; $display("FAIL nominal_wave at sample %0d got=%b exp=%b", e, cap_tx[e], exp_tx(e)); end
        checks++; if (done_count(FRAME_LEN + 20) != 1 || cap_done[FRAME_LEN] !== 1'b1) begin
            failures++; $display("FAIL nominal_done count=%0d at_%0d=%b exp one pulse at %0d", done_count(FRAME_LEN + 20), FRAME_LEN, cap_done[FRAME_LEN], FRAME_LEN);
        end
        e = first_busy_err(FRAME_LEN + 20);
        checks++; if (e >= 0) begin failures++; $display("FAIL nominal_busy at sample %0d got=%b exp=%b", e, cap_busy[e], (e < FRAME_LEN)); end
    endtask

`ifdef UART_FRAME_PARITY_EN
    task automatic test_parity();
        load_exp(56'hA5_C2_12_34_56_78_CA);
        send(KIND_OTHER, 5'd1, 32'h12345678);
        capture(FRAME_LEN + 20, -1);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (cap_tx[(k*BPF + 9)*CPB + CPB/2] !== ^exp_b[k]) begin
                failures++; $display("FAIL parity_byte%0d got=%b exp=%b", k, cap_tx[(k*BPF + 9)*CPB + CPB/2], ^exp_b[k]);
            end
        end
        checks++; if (cap_done[308] !== 1'b1) begin failures++; $display("FAIL parity_done_308 got=%b exp=1", cap_done[308]); end
    endtask
`endif

    task automatic test_zeros();
        int e;
        load_exp(56'hA5_00_00_00_00_00_00);
        send(KIND_REG, 5'd0, 32'h0);
        capture(FRAME_LEN + 20, -1);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (decode(k) !== exp_b[k]) begin failures++; $display("FAIL zeros_byte%0d got=%h exp=%h", k, decode(k), exp_b[k]); end
        end
        // Sample-exact comparison pins every bit width and the high line
        // outside start/data bits.
        e = first_tx_err(FRAME_LEN + 20);
        checks++; if (e >= 0) begin failures++; $display("FAIL zeros_wave at sample %0d got=%b exp=%b", e, cap_tx[e], exp_tx(e)); end
        checks++; if (done_count(FRAME_LEN + 20) != 1 || cap_done[FRAME_LEN] !== 1'b1) begin
            failures++; $display("FAIL zeros_done count=%0d exp one pulse at %0d", done_count(FRAME_LEN + 20), FRAME_LEN);
        end
    endtask

    task automatic test_drop_while_busy();
        int e;
        load_exp(56'hA5_00_DE_AD_BE_EF_22);
        send(KIND_REG, 5'd0, 32'hDEADBEEF);
        capture(FRAME_LEN + 150, 50);
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (decode(k) !== exp_b[k]) begin failures++; $display("FAIL drop_byte%0d got=%h exp=%h", k, decode(k), exp_b[k]); end
        end
        e = first_tx_err(FRAME_LEN + 150);
        checks++; if (e >= 0) begin failures++; $display("FAIL drop_wave at sample %0d got=%b exp=%b", e, cap_tx[e], exp_tx(e)); end
        checks++; if (done_count(FRAME_LEN + 150) != 1) begin failures++; $display("FAIL drop_done_count got=%0d exp=1", done_count(FRAME_LEN + 150)); end
        e = first_busy_err(FRAME_LEN + 150);
        checks++; if (e >= 0) begin failures++; $display("FAIL drop_busy at sample %0d got=%b exp=%b", e, cap_busy[e], (e < FRAME_LEN)); end
    endtask

    task automatic test_back_to_back();
        int e;
        send(KIND_OTHER, 5'd1, 32'h12345678);
        capture(FRAME_LEN, -1);
        // Now in the cycle where done should be high.
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_done_cycle done=%b busy=%b exp done=1 busy=0", done, busy); end
        kind = KIND_ALU; addr = 5'd2; data = 32'h00FF00FF; uart_send_en = 1'b1;
        @(negedge clk);
        uart_send_en = 1'b0;
        load_exp(56'hA5_44_00_FF_00_FF_44);
        capture(FRAME_LEN + 20, -1);
        checks++; if (cap_tx[0] !== 1'b0 || cap_busy[0] !== 1'b1) begin
            failures++; $display("FAIL b2b_start tx=%b busy=%b exp tx=0 busy=1", cap_tx[0], cap_busy[0]);
        end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (decode(k) !== exp_b[k]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", k, decode(k), exp_b[k]); end
        end
        e = first_tx_err(FRAME_LEN + 20);
        checks++; if (e >= 0) begin failures++; $display("FAIL b2b_wave at sample %0d got=%b exp=%b", e, cap_tx[e], exp_tx(e)); end
        checks++; if (cap_done[FRAME_LEN] !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1 at %0d", cap_done[FRAME_LEN], FRAME_LEN); end
    endtask

    task automatic test_reset_mid_frame();
        int bad_tx = 0, bad_busy = 0, n_done = 0;
        send(KIND_INST, 5'd3, 32'h0000_0000);
        // Middle of B3's start/early data bits.
        capture(3 * BPF * CPB + 2, -1);
        checks++; if (busy !== 1'b1 || tx !== 1'b0) begin failures++; $display("FAIL midrst_pre busy=%b tx=%b exp busy=1 tx=0", busy, tx); end
        resetn = 1'b0;
        @(negedge clk);
        checks++; if (tx !== 1'b1)   begin failures++; $display("FAIL midrst_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        resetn = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        checks++; if (n_done != 0)   begin failures++; $display("FAIL midrst_done got=%0d pulses exp=0", n_done); end
        checks++; if (bad_tx != 0 || bad_busy != 0) begin failures++; $display("FAIL midrst_idle tx_low=%0d busy_high=%0d exp=0", bad_tx, bad_busy); end
    endtask

    initial begin
        test_reset();
        test_nominal();
`ifdef UART_FRAME_PARITY_EN
        test_parity();
`endif
        test_zeros();
        test_drop_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
